// File: rtl/display_scan_ctrl.sv
// Purpose : captures two numbers, converts them to BCD one bit per cycle and
//           multiplexes the resulting 8 digits onto a shared nibble with a
//           rotating active-low enable.
// Latency : Busy high for 30 cycles after an accepted Load. Digits are
//           committed and Done pulses on the 30th edge.
// Backpressure : Load is accepted only when idle. Loads that arrive while
//           Busy is high are dropped and are not queued.
//
// Ports:
//   Clk, Rst_n              clock and asynchronous active-low reset
//   Load                    capture NumberA_in / NumberB_in when idle
//   NumberA_in, NumberB_in  unsigned values shown on digits 3..0 and 7..4
//   Blank                   forces every digit enable inactive while high
//   Busy, Done              conversion in progress / one-cycle commit pulse
//   Digit                   BCD nibble of the enabled digit (4'hF = blank)
//   en_out                  one-hot, active-low digit enables
module display_scan_ctrl #(
    parameter int NUM_WIDTH  = 32,
    parameter int PRESCALE_W = 17
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Load,
    input  logic [NUM_WIDTH-1:0] NumberA_in,
    input  logic [NUM_WIDTH-1:0] NumberB_in,
    input  logic                 Blank,
    output logic                 Busy,
    output logic                 Done,
    output logic [3:0]           Digit,
    output logic [7:0]           en_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV_A = 2'd1;
    localparam logic [1:0] CONV_B = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    // Four decimal digits cover 0..9999. Anything at or above this limit,
    // judged on the full input width, is shown as four blank digits.
    localparam logic [NUM_WIDTH-1:0] DEC_LIMIT = NUM_WIDTH'(10000);
    localparam logic [3:0] LAST_BIT = 4'd13;
    // B holds one extra cycle past its last shift before moving to COMMIT.
    localparam logic [3:0] B_HOLD   = 4'd14;
    localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [3:0]            bitCnt;
    logic [13:0]           shiftReg;
    logic [13:0]           numB;
    logic [15:0]           bcdReg;
    logic [15:0]           bcdA;
    logic                  ovfA;
    logic                  ovfB;
    logic [31:0]           digRegs;
    logic [PRESCALE_W-1:0] prescale;
    logic [2:0]            scanIdx;
    logic [15:0]           bcdAdj;
    logic [15:0]           bcdNext;

    // Double-dabble correction: any nibble of 5 or more gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [15:0] addThree(input logic [15:0] bcdIn);
        logic [15:0] res;
        res = bcdIn;
        for (int n = 0; n < 4; n++) begin
            if (res[n*4 +: 4] >= 4'd5) begin
                res[n*4 +: 4] = res[n*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    always_comb begin
        bcdAdj  = addThree(bcdReg);
        bcdNext = {bcdAdj[14:0], shiftReg[13]};
    end

    // Conversion FSM. The digit registers are only written in COMMIT, so the
    // scanned display never shows a half-converted number.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            bitCnt   <= 4'd0;
            shiftReg <= 14'd0;
            numB     <= 14'd0;
            bcdReg   <= 16'd0;
            bcdA     <= 16'd0;
            ovfA     <= 1'b0;
            ovfB     <= 1'b0;
            digRegs  <= 32'hFFFF_FFFF;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load && !Busy) begin
                        shiftReg <= NumberA_in[13:0];
                        numB     <= NumberB_in[13:0];
                        ovfA     <= (NumberA_in >= DEC_LIMIT);
                        ovfB     <= (NumberB_in >= DEC_LIMIT);
                        bcdReg   <= 16'd0;
                        bitCnt   <= 4'd0;
                        Busy     <= 1'b1;
                        state    <= CONV_A;
                    end
                end
                CONV_A: begin
                    if (bitCnt == LAST_BIT) begin
                        // A is finished; park it and restart the shifter on B.
                        bcdA     <= bcdNext;
                        bcdReg   <= 16'd0;
                        shiftReg <= numB;
                        bitCnt   <= 4'd0;
                        state    <= CONV_B;
                    end else begin
                        bcdReg   <= bcdNext;
                        shiftReg <= {shiftReg[12:0], 1'b0};
                        bitCnt   <= bitCnt + 4'd1;
                    end
                end
                CONV_B: begin
                    if (bitCnt == B_HOLD) begin
                        state <= COMMIT;
                    end else begin
                        bcdReg   <= bcdNext;
                        shiftReg <= {shiftReg[12:0], 1'b0};
                        bitCnt   <= bitCnt + 4'd1;
                    end
                end
                COMMIT: begin
                    digRegs <= {(ovfB ? 16'hFFFF : bcdReg),
                                (ovfA ? 16'hFFFF : bcdA)};
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Scan path: free-running prescaler advances the digit index on wrap.
    // Outputs are registered from the index, so they follow it by one cycle,
    // and a commit on the same edge as an index step appears one cycle later.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prescale <= '0;
            scanIdx  <= 3'd0;
            Digit    <= 4'hF;
            en_out   <= 8'hFF;
        end else begin
            prescale <= prescale + PRE_ONE;
            if (&prescale) begin
                scanIdx <= scanIdx + 3'd1;
            end
            en_out <= Blank ? 8'hFF : ~(8'h01 << scanIdx);
            Digit  <= digRegs[{scanIdx, 2'b00} +: 4];
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Purpose : directed self-checking bench for display_scan_ctrl (PRESCALE_W=2).
// Latency : checks the 30-cycle Busy window and Done position.
// Backpressure : checks that a Load during Busy is dropped.
module tb_display_scan_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic        Load;
    logic [31:0] NumberA_in;
    logic [31:0] NumberB_in;
    logic        Blank;
    logic        Busy;
    logic        Done;
    logic [3:0]  Digit;
    logic [7:0]  en_out;

    int checks;
    int failures;

    display_scan_ctrl #(
        .NUM_WIDTH (32),
        .PRESCALE_W(2)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Load      (Load),
        .NumberA_in(NumberA_in),
        .NumberB_in(NumberB_in),
        .Blank     (Blank),
        .Busy      (Busy),
        .Done      (Done),
        .Digit     (Digit),
        .en_out    (en_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Starts one conversion and watches a fixed 45-sample window.
    // Sample 0 is taken just after the accepting edge.
    task automatic runConv(input logic [31:0] a, input logic [31:0] b,
                           input int reloadAt, input logic [31:0] a2,
                           input logic [31:0] b2, output bit busyAtAccept,
                           output int busyCyc, output int doneCnt,
                           output int donePos, output bit sawNonF);
        NumberA_in = a;
        NumberB_in = b;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        busyAtAccept = Busy;
        busyCyc = 0;
        doneCnt = 0;
        donePos = -1;
        sawNonF = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (Busy) busyCyc++;
            if (Done) begin
                doneCnt++;
                donePos = i;
            end
            if (Busy && Digit !== 4'hF) sawNonF = 1'b1;
            if (i == reloadAt) begin
                NumberA_in = a2;
                NumberB_in = b2;
                Load = 1'b1;
            end else begin
                Load = 1'b0;
            end
            tick();
        end
        Load = 1'b0;
    endtask

    // Collects the nibble shown for each enable position, packed digit 7..0.
    task automatic captureDigits(output logic [31:0] d, output bit timedOut);
        logic [7:0] seen;
        seen = 8'h00;
        d = 32'h0;
        for (int c = 0; c < 80 && seen != 8'hFF; c++) begin
            tick();
            for (int j = 0; j < 8; j++) begin
                if (en_out === ~(8'h01 << j)) begin
                    d[j*4 +: 4] = Digit;
                    seen[j] = 1'b1;
                end
            end
        end
        timedOut = (seen != 8'hFF);
    endtask

    task automatic checkDigits(input string name, input logic [31:0] exp);
        logic [31:0] got;
        bit to;
        captureDigits(got, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL %s: digit scan timed out", name);
        end else if (got !== exp) begin
            failures++;
            $display("FAIL %s: digits got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        Load = 1'b0;
        Blank = 1'b0;
        NumberA_in = 32'd0;
        NumberB_in = 32'd0;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++;
        if (Done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", Done); end
        checks++;
        if (Digit !== 4'hF) begin failures++; $display("FAIL reset_digit: got %h expected f", Digit); end
        checks++;
        if (en_out !== 8'hFF) begin failures++; $display("FAIL reset_en: got %h expected ff", en_out); end
    endtask

    task automatic test_basic;
        bit acc, nonF;
        int bc, dc, dp;
        // Release reset with Load already high: first edge must accept it.
        Rst_n = 1'b1;
        runConv(32'd1234, 32'd56, -1, 32'd0, 32'd0, acc, bc, dc, dp, nonF);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL basic_accept: busy got %b expected 1", acc); end
        checks++;
        if (bc != 30) begin failures++; $display("FAIL basic_busy_len: got %0d expected 30", bc); end
        checks++;
        if (dc != 1 || dp != 30) begin
            failures++;
            $display("FAIL basic_done: count %0d at %0d expected 1 at 30", dc, dp);
        end
        checks++;
        if (nonF) begin failures++; $display("FAIL basic_hold: digit changed before commit expected f"); end
        checkDigits("basic_digits", 32'h0056_1234);
    endtask

    task automatic test_overflow;
        bit acc, nonF;
        int bc, dc, dp;
        runConv(32'd10000, 32'd9999, -1, 32'd0, 32'd0, acc, bc, dc, dp, nonF);
        checkDigits("ovf_10000_9999", 32'h9999_FFFF);
        // Low 14 bits of 65536 are zero; only a full-width compare blanks it.
        runConv(32'hFFFF_FFFF, 32'd65536, -1, 32'd0, 32'd0, acc, bc, dc, dp, nonF);
        checkDigits("ovf_all_ones", 32'hFFFF_FFFF);
    endtask

    task automatic test_back_to_back;
        bit acc, nonF;
        int bc, dc, dp;
        runConv(32'd2468, 32'd1357, 5, 32'd9999, 32'd1111, acc, bc, dc, dp, nonF);
        checks++;
        if (bc != 30) begin failures++; $display("FAIL reload_busy_len: got %0d expected 30", bc); end
        checks++;
        if (dc != 1) begin failures++; $display("FAIL reload_done_count: got %0d expected 1", dc); end
        checkDigits("reload_digits", 32'h1357_2468);
    endtask

    task automatic test_reset_mid;
        int doneSeen, busySeen;
        NumberA_in = 32'd1111;
        NumberB_in = 32'd2222;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (10) tick();
        Rst_n = 1'b0;
        #1;
        checks++;
        if (en_out !== 8'hFF) begin failures++; $display("FAIL mid_reset_en: got %h expected ff", en_out); end
        checks++;
        if (Digit !== 4'hF) begin failures++; $display("FAIL mid_reset_digit: got %h expected f", Digit); end
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", Busy); end
        tick();
        tick();
        Rst_n = 1'b1;
        doneSeen = 0;
        busySeen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) doneSeen++;
            if (Busy) busySeen++;
        end
        checks++;
        if (doneSeen != 0 || busySeen != 0) begin
            failures++;
            $display("FAIL mid_reset_abort: done %0d busy %0d expected 0 0", doneSeen, busySeen);
        end
        checkDigits("mid_reset_cleared", 32'hFFFF_FFFF);
    endtask

    task automatic test_scan;
        logic [7:0] exp;
        int bad;
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp = ~(8'h01 << (((k - 1) / 4) % 8));
            checks++;
            if (en_out !== exp) begin
                failures++;
                bad++;
                if (bad < 5) $display("FAIL scan_en cycle %0d: got %h expected %h", k, en_out, exp);
            end
        end
    endtask

    task automatic test_blank;
        logic [7:0] exp;
        int bad;
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        bad = 0;
        for (int k = 1; k <= 24; k++) begin
            Blank = (k >= 6 && k <= 11);
            tick();
            exp = (k >= 6 && k <= 11) ? 8'hFF : ~(8'h01 << (((k - 1) / 4) % 8));
            checks++;
            if (en_out !== exp) begin
                failures++;
                bad++;
                if (bad < 5) $display("FAIL blank_en cycle %0d: got %h expected %h", k, en_out, exp);
            end
        end
        Blank = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_scan();
        test_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
